// File: rtl/instr_loader.sv
// instr_loader: buffers a short program from pins, then issues it one word per cycle.
// Ports: clock/reset_n (async active-low); in_data/in_valid/in_ready load handshake;
// start/clear control; instruction/instr_valid/instr_idx issue stream;
// proc_reset one-cycle scheduler reset; busy (PRE or RUN); done (program issued).
module instr_loader #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12,
  parameter logic [WIDTH-1:0] NOP = 'h00C
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     start,
  input  logic                     clear,
  output logic [WIDTH-1:0]         instruction,
  output logic                     instr_valid,
  output logic [$clog2(DEPTH)-1:0] instr_idx,
  output logic                     proc_reset,
  output logic                     busy,
  output logic                     done
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  typedef enum logic [1:0] {LOAD, PRE, RUN, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              xfer, last;
  assign in_ready = (state_q == LOAD) && (count_q < CW'(DEPTH));
  assign xfer     = in_ready && in_valid;
  assign last     = {1'b0, idx_q} == count_q - 1'b1;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    if (clear) begin
      state_d = LOAD;
      count_d = '0;
      idx_d   = '0;
    end else if (state_q == LOAD) begin
      count_d = count_q + CW'(xfer);
      // a word arriving with start still counts toward a non-empty program
      state_d = (start && (count_q != '0 || xfer)) ? PRE : LOAD;
    end else if (state_q == PRE) begin
      idx_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      idx_d   = last ? '0 : idx_q + 1'b1;
      state_d = last ? DONE : RUN;
    end else begin
      state_d = start ? PRE : DONE;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= LOAD;
      count_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
    end
  end
  always_ff @(posedge clock) begin
    if (xfer && !clear) mem_q[count_q[IW-1:0]] <= in_data;
  end
  assign instr_valid = state_q == RUN;
  assign instruction = instr_valid ? mem_q[idx_q] : NOP;
  assign instr_idx   = instr_valid ? idx_q : '0;
  assign proc_reset  = state_q == PRE;
  assign busy        = (state_q == PRE) || (state_q == RUN);
  assign done        = state_q == DONE;
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 8; program slots, power of two, 2..8.
REQ-002 SHALL have parameter WIDTH, default 12; instruction width.
REQ-003 SHALL have parameter NOP, default 12'h00C; idle instruction (both operands immediate 0, op 0).
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  WIDTH  instruction word from pins.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  loader can accept a word.
REQ-009 start  input  1  begin issuing the loaded program.
REQ-010 clear  input  1  discard the program, return to LOAD.
REQ-011 instruction  output  WIDTH  word driven to the processor.
REQ-012 instr_valid  output  1  instruction is a program word.
REQ-013 instr_idx  output  $clog2(DEPTH)  slot index of the issued word.
REQ-014 proc_reset  output  1  one-cycle reset pulse to the processor's scheduler.
REQ-015 busy  output  1  high in PRE or RUN.
REQ-016 done  output  1  program fully issued.

Function
REQ-017 SHALL implement states LOAD, PRE, RUN, DONE, held in a registered state machine.
REQ-018 SHALL store words in a DEPTH x WIDTH register array; count register width $clog2(DEPTH)+1.
REQ-019 LOAD: in_ready = (count < DEPTH); a transfer occurs when in_valid & in_ready; word written to slot count; count increments the same edge.
REQ-020 LOAD with count == DEPTH: in_ready = 0; in_valid ignored, no overwrite, no wrap.
REQ-021 LOAD & start & count > 0 -> PRE next cycle; a transfer in the same cycle as start SHALL still be stored and included in the program.
REQ-022 LOAD & start & count == 0 (no simultaneous transfer): ignored, remain LOAD.
REQ-023 PRE: lasts exactly one cycle; proc_reset = 1; idx cleared to 0; -> RUN.
REQ-024 RUN: instruction = mem[idx], instr_valid = 1, instr_idx = idx, one word per cycle, no stalls.
REQ-025 RUN: idx increments each cycle; after issuing slot count-1 -> DONE; latency from start to first valid word = 2 cycles.
REQ-026 DONE: done = 1, instr_valid = 0; start -> PRE (replay same program); clear -> LOAD.
REQ-027 in_ready SHALL be 0 in PRE, RUN, DONE; start ignored in PRE and RUN.
REQ-028 clear in any state: next cycle LOAD, count = 0, idx = 0; clear has priority over start and over a transfer in the same cycle; stored contents are not required to be zeroed.
REQ-029 Whenever instr_valid = 0, instruction SHALL equal NOP and instr_idx SHALL equal 0.
REQ-030 All outputs SHALL be registered or decoded from state only; no combinational path from in_data to instruction.

Reset
REQ-031 reset_n low SHALL asynchronously force state LOAD, count 0, idx 0, regardless of clock.
REQ-032 During and after reset: in_ready = 1, instr_valid = 0, instruction = NOP, instr_idx = 0, proc_reset = 0, busy = 0, done = 0.
REQ-033 reset_n asserted mid-RUN SHALL abort issue immediately; the program is lost (count = 0).
REQ-034 Memory array contents need not be reset.

Verification
REQ-035 Load 3 words 12'h111, 12'h222, 12'h333, then start -> proc_reset high 1 cycle, then 12'h111/idx0, 12'h222/idx1, 12'h333/idx2 on consecutive cycles, then done = 1, instruction = 12'h00C.
REQ-036 Offer 10 words with DEPTH = 8 -> exactly 8 accepted, in_ready low after the 8th, run issues 8 words, words 9 and 10 never appear.
REQ-037 start with count 0 -> stays LOAD, busy = 0, no proc_reset; start together with the first transfer (12'hABC) -> run of 1 word, 12'hABC at idx 0.
REQ-038 In DONE, pulse start -> identical sequence replays; pulse clear -> LOAD, in_ready = 1, subsequent start with no load ignored.
REQ-039 reset_n low for half a cycle at idx 1 of a 4-word run -> outputs take reset values before the next edge; no further valid words.
REQ-040 clear and start asserted together in LOAD with count 2 -> LOAD, count 0, no proc_reset.
